mmio_uart_tx: RTL

Memory-mapped UART transmitter that sits on the data-memory bus of the single-cycle core and acts as a bus responder. The core issues stores and loads, and this block answers them. Stores to TXDATA push bytes into a small FIFO, and an 8N1 serializer drives them out on a serial pin. Loads return status and control registers combinationally, so the single-cycle core completes each access in one cycle.

---
 rtl/mmio_uart_tx.sv | 92 +++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO, answering bus loads combinationally
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic        we,
    output logic [31:0] rd,
    output logic        sel,
    output logic        tx,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    st_q, st_d;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          ovf_q, en_q, ie_q;
    logic [1:0]    off;
    logic          full, empty, busy, wr_tx, push, pop, bit_end;
    logic          unused_bits;

    assign sel         = addr[31:4] == BASE_ADDR[31:4];
    assign off         = addr[3:2];
    assign full        = cnt_q == CW'(FIFO_DEPTH);
    assign empty       = cnt_q == '0;
    assign busy        = st_q != IDLE;
    assign wr_tx       = we & sel & (off == 2'd0);
    assign push        = wr_tx & ~full;
    assign bit_end     = baud_q == BW'(CLKS_PER_BIT - 1);
    assign pop         = en_q & ~empty & ((st_q == IDLE) | ((st_q == STOP) & bit_end));
    assign unused_bits = ^{wd[31:8], addr[1:0]};

    // pop has priority so STOP can chain straight into the next START
    assign st_d = pop ? START : !bit_end ? st_q : (st_q == START) ? DATA :
                  (st_q == DATA) ? ((bit_q == 3'd7) ? STOP : DATA) : IDLE;

    assign tx  = (st_q == START) ? 1'b0 : (st_q == DATA) ? shift_q[bit_q] : 1'b1;
    assign irq = ie_q & empty & ~busy;
    assign rd  = !sel ? '0 :
                 (off == 2'd1) ? {24'd0, 4'(cnt_q), ovf_q, busy, empty, full} :
                 (off == 2'd2) ? {30'd0, ie_q, en_q} : '0;

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= wd[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            st_q    <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ovf_q   <= 1'b0;
            en_q    <= 1'b1;
            ie_q    <= 1'b0;
        end else begin
            st_q   <= st_d;
            baud_q <= (st_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
            cnt_q  <= cnt_q + CW'(push) - CW'(pop);
            if (st_q == DATA && bit_end) bit_q <= bit_q + 1'b1;
            if (push) wp_q <= wp_q + 1'b1;
            if (pop) begin
                shift_q <= mem_q[rp_q];
                rp_q    <= rp_q + 1'b1;
            end
            if (wr_tx & full) ovf_q <= 1'b1;
            else if (we & sel & (off == 2'd1) & wd[3]) ovf_q <= 1'b0;
            if (we & sel & (off == 2'd2)) begin
                en_q <= wd[0];
                ie_q <= wd[1];
            end
        end
    end
endmodule
